// File: rtl/rvvi_frame_streamer_pkg.sv
// Shared types and sizing helpers for the buffered RVVI-over-Ethernet frame streamer.
package rvvi_frame_streamer_pkg;

    typedef struct packed {
        logic [31:0] XLEN;
    } cvw_t;

    localparam cvw_t CVW_RV64 = '{XLEN: 32'd64};

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } rvvi_stream_state_t;

    function automatic int rvvi_record_width(input int xlen, input int max_csrs);
        return 72 + 5 * xlen + max_csrs * (xlen + 16);
    endfunction

    // 14 header bytes: EthType (2) + destination MAC (6) + source MAC (6)
    function automatic int rvvi_frame_bytes(input int xlen, input int max_csrs);
        return 14 + rvvi_record_width(xlen, max_csrs) / 8;
    endfunction

endpackage

// File: rtl/rvvi_frame_streamer_if.sv
// AXI4 write-data channel carrying streamed RVVI frames towards the Ethernet MAC.
interface rvvi_frame_streamer_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0]   RvviAxiWdata;
    logic [WORD_W/8-1:0] RvviAxiWstrb;
    logic                RvviAxiWlast;
    logic                RvviAxiWvalid;
    logic                RvviAxiWready;

    modport master (
        output RvviAxiWdata, RvviAxiWstrb, RvviAxiWlast, RvviAxiWvalid,
        input  RvviAxiWready
    );

    modport slave (
        input  RvviAxiWdata, RvviAxiWstrb, RvviAxiWlast, RvviAxiWvalid,
        output RvviAxiWready
    );
endinterface

// File: rtl/rvvi_frame_streamer_sync_fifo.sv
// Synchronous record FIFO with first-word fall-through head; pointers carry a wrap bit.
module rvvi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok_s, pop_ok_s;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok_s};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok_s};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: contents are only observable behind a valid pointer.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/rvvi_frame_streamer.sv
// Buffers RVVI records and streams each one, wrapped in an Ethernet header, as an AXI4 write burst.
module rvvi_frame_streamer
    import rvvi_frame_streamer_pkg::*;
#(
    parameter cvw_t        P          = CVW_RV64,
    parameter int          MAX_CSRS   = 3,
    parameter int          WORD_W     = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] INIT_WAIT  = 32'd4,
    parameter logic [47:0] DST_MAC    = 48'h8F54_0000_1654,
    parameter logic [47:0] SRC_MAC    = 48'h4502_1111_6843,
    parameter logic [15:0] ETH_TYPE   = 16'h005c,
    localparam int         RVVI_W     = rvvi_record_width(int'(P.XLEN), MAX_CSRS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [RVVI_W-1:0]        rvvi,
    input  logic                     valid,
    output logic                     RVVIStall,
    rvvi_frame_streamer_if.master    axi,
    input  logic [31:0]              InnerPktDelay,
    output logic [31:0]              FrameCount,
    output logic [15:0]              DropCount
);
    localparam int FRAME_BYTES = rvvi_frame_bytes(int'(P.XLEN), MAX_CSRS);
    localparam int STRB_W      = WORD_W / 8;
    localparam int NBEATS      = (FRAME_BYTES * 8 + WORD_W - 1) / WORD_W;
    localparam int FRAME_W     = NBEATS * WORD_W;
    localparam int BEAT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LAST_BYTES  = FRAME_BYTES % STRB_W;

    localparam logic [STRB_W-1:0] LAST_STRB = (LAST_BYTES == 0) ? {STRB_W{1'b1}}
                                                                 : STRB_W'((1 << LAST_BYTES) - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    localparam logic [1:0] ST_INIT = INIT;
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SEND = SEND;
    localparam logic [1:0] ST_GAP  = GAP;

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [31:0]       gap_q, gap_d;
    logic [31:0]       init_q, init_d;
    logic [31:0]       frame_count_q, frame_count_d;
    logic [15:0]       drop_count_q, drop_count_d;

    logic [RVVI_W-1:0]  head_s;
    logic               full_s, empty_s, push_s, pop_s, send_s, last_beat_s;
    logic [FRAME_W-1:0] frame_s;
    logic [WORD_W-1:0]  beats_s [NBEATS];

    rvvi_sync_fifo #(.WIDTH(RVVI_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (rvvi),
        .head  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign RVVIStall = (state_q == ST_INIT) | full_s;
    assign push_s    = valid & ~RVVIStall;

    // Zero pad above the record comes from the cast; source MAC lands in beat 0.
    assign frame_s = FRAME_W'({head_s, ETH_TYPE, DST_MAC, SRC_MAC});

    for (genvar g = 0; g < NBEATS; g++) begin : g_beat
        assign beats_s[g] = frame_s[g*WORD_W +: WORD_W];
    end

    assign send_s            = (state_q == ST_SEND);
    assign last_beat_s       = (beat_q == LAST_BEAT);
    assign axi.RvviAxiWvalid = send_s;
    assign axi.RvviAxiWdata  = beats_s[beat_q];
    assign axi.RvviAxiWstrb  = last_beat_s ? LAST_STRB : {STRB_W{1'b1}};
    assign axi.RvviAxiWlast  = send_s & last_beat_s;
    assign FrameCount        = frame_count_q;
    assign DropCount         = drop_count_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        init_d  = init_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_q == INIT_WAIT) begin
                    state_d = ST_IDLE;
                end else begin
                    init_d = init_q + 32'd1;
                end
            end
            ST_IDLE: begin
                if (!empty_s) begin
                    state_d = ST_SEND;
                    beat_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (axi.RvviAxiWready && last_beat_s) begin
                    pop_s  = 1'b1;
                    beat_d = '0;
                    // The IDLE cycle that follows GAP is itself one of the idle cycles.
                    if (InnerPktDelay > 32'd1) begin
                        state_d = ST_GAP;
                        gap_d   = InnerPktDelay - 32'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (axi.RvviAxiWready) begin
                    beat_d = beat_q + BEAT_W'(1);
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_GAP: begin
                if (gap_q <= 32'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_comb begin
        frame_count_d = frame_count_q + {31'd0, pop_s};
        if (valid && RVVIStall && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            beat_q        <= '0;
            gap_q         <= '0;
            init_q        <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            gap_q         <= gap_d;
            init_q        <= init_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_rvvi_frame_streamer.sv
// Scoreboard bench for rvvi_frame_streamer: XLEN=64, MAX_CSRS=3, WORD_W=32 (24 beats per frame).
module tb_rvvi_frame_streamer;
    import rvvi_frame_streamer_pkg::*;

    localparam int RVVI_W  = 632;
    localparam int NBEATS  = 24;
    localparam int FRAME_W = 768;

    logic               clk = 1'b0;
    logic               reset;
    logic [RVVI_W-1:0]  rvvi;
    logic               valid;
    logic               rvvi_stall;
    logic [31:0]        inner_pkt_delay;
    logic [31:0]        frame_count;
    logic [15:0]        drop_count;

    rvvi_frame_streamer_if #(.WORD_W(32)) axi ();

    rvvi_frame_streamer #(
        .P(CVW_RV64), .MAX_CSRS(3), .WORD_W(32), .FIFO_DEPTH(4), .INIT_WAIT(32'd4),
        .DST_MAC(48'h8F54_0000_1654), .SRC_MAC(48'h4502_1111_6843), .ETH_TYPE(16'h005c)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rvvi          (rvvi),
        .valid         (valid),
        .RVVIStall     (rvvi_stall),
        .axi           (axi),
        .InnerPktDelay (inner_pkt_delay),
        .FrameCount    (frame_count),
        .DropCount     (drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rdy_mode = 1;
    int exp_frames = 0;
    int exp_drop = 0;
    logic [FRAME_W-1:0] exp_q [$];
    int first_cyc_q [$];
    int last_cyc_q [$];

    int mon_beat = 0;
    int mon_frames = 0;
    int cur_first = 0;
    logic [FRAME_W-1:0] cur_frame;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic        prev_last;
    logic [3:0]  prev_strb;
    logic [31:0] prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [FRAME_W-1:0] act, input logic [FRAME_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [RVVI_W-1:0] mk_rec(input int k);
        logic [RVVI_W-1:0] r;
        for (int i = 0; i < RVVI_W / 8; i++) r[8*i +: 8] = 8'(k * 37 + i * 3 + 1);
        return r;
    endfunction

    function automatic logic [FRAME_W-1:0] mk_frame(input logic [RVVI_W-1:0] r);
        return FRAME_W'({r, 16'h005c, 48'h8F54_0000_1654, 48'h4502_1111_6843});
    endfunction

    // Monitor: collects handshaken beats, checks AXI hold rules, compares whole frames.
    always @(negedge clk) begin
        if (reset) begin
            mon_beat  = 0;
            cur_frame = '0;
            prev_v    = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", axi.RvviAxiWvalid, 1'b1);
                chk("hold_beat", {axi.RvviAxiWlast, axi.RvviAxiWstrb, axi.RvviAxiWdata},
                    {prev_last, prev_strb, prev_data});
            end
            if (axi.RvviAxiWvalid && axi.RvviAxiWready) begin
                if (mon_beat == 0) cur_first = cyc;
                chk("strb", axi.RvviAxiWstrb, (mon_beat == NBEATS - 1) ? 4'b0001 : 4'b1111);
                chk("last", axi.RvviAxiWlast, mon_beat == NBEATS - 1);
                if (mon_beat < NBEATS) cur_frame[mon_beat*32 +: 32] = axi.RvviAxiWdata;
                if (axi.RvviAxiWlast) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL frame: got unexpected frame want none");
                    end else begin
                        chk("frame", cur_frame, exp_q.pop_front());
                    end
                    first_cyc_q.push_back(cur_first);
                    last_cyc_q.push_back(cyc);
                    mon_frames++;
                    mon_beat  = 0;
                    cur_frame = '0;
                end else begin
                    mon_beat++;
                end
            end
            prev_v    = axi.RvviAxiWvalid;
            prev_r    = axi.RvviAxiWready;
            prev_last = axi.RvviAxiWlast;
            prev_strb = axi.RvviAxiWstrb;
            prev_data = axi.RvviAxiWdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       axi.RvviAxiWready = 1'b0;
            1:       axi.RvviAxiWready = 1'b1;
            default: axi.RvviAxiWready = (cyc % 3 == 0);
        endcase
    endtask

    task automatic push(input logic [RVVI_W-1:0] rec, input bit acc);
        rvvi  = rec;
        valid = 1'b1;
        chk("push_stall", rvvi_stall, !acc);
        if (acc) begin
            exp_q.push_back(mk_frame(rec));
            exp_frames++;
        end else begin
            exp_drop++;
        end
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (mon_frames < n && t < budget) begin
            tick();
            t++;
        end
        chk("frames_done", mon_frames, n);
    endtask

    initial begin
        int t;
        int span;
        int base;
        reset = 1'b1;
        valid = 1'b1;
        rvvi = mk_rec(1);
        inner_pkt_delay = 32'd0;
        axi.RvviAxiWready = 1'b1;
        repeat (3) tick();

        // INIT hold-off with valid held high from reset, then single frame latency and layout
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("init_stall", rvvi_stall, i < 5);
            if (i < 5) begin
                exp_drop++;
                tick();
            end
        end
        exp_q.push_back(mk_frame(mk_rec(1)));
        exp_frames++;
        tick();
        valid = 1'b0;
        chk("lat_wvalid_c6", axi.RvviAxiWvalid, 1'b0);
        tick();
        chk("lat_wvalid_c7", axi.RvviAxiWvalid, 1'b1);
        chk("beat0", axi.RvviAxiWdata, 32'h1111_6843);
        wait_frames(1, 100);
        span = (last_cyc_q.size() > 0) ? last_cyc_q[0] - first_cyc_q[0] : -1;
        chk("consecutive_span", span, 23);
        chk("frame_count_1", frame_count, exp_frames);
        chk("drop_count_init", drop_count, exp_drop);

        // Backpressure: ready pattern 1,0,0 repeating
        rdy_mode = 2;
        push(mk_rec(2), 1'b1);
        wait_frames(2, 300);
        rdy_mode = 1;
        tick();

        // Fill: ready low, five back-to-back pushes, the fifth refused
        rdy_mode = 0;
        tick();
        for (int k = 0; k < 5; k++) push(mk_rec(10 + k), k < 4);
        chk("drop_count_fill", drop_count, exp_drop);
        rdy_mode = 1;
        tick();
        wait_frames(6, 400);
        chk("frame_count_fill", frame_count, exp_frames);

        // Inter-frame gap of 10
        inner_pkt_delay = 32'd10;
        push(mk_rec(20), 1'b1);
        push(mk_rec(21), 1'b1);
        wait_frames(8, 400);
        span = (first_cyc_q.size() > 7) ? first_cyc_q[7] - last_cyc_q[6] : -1;
        chk("gap_cycles", span, 11);
        inner_pkt_delay = 32'd0;

        // Reset while beat 10 of a frame is on the bus
        push(mk_rec(30), 1'b1);
        t = 0;
        while (mon_beat != 10 && t < 200) begin
            tick();
            t++;
        end
        chk("reach_beat10", mon_beat, 10);
        rdy_mode = 0;
        axi.RvviAxiWready = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        exp_frames = 0;
        exp_drop = 0;
        tick();
        chk("rst_wvalid", axi.RvviAxiWvalid, 1'b0);
        chk("rst_frame_count", frame_count, 32'd0);
        chk("rst_drop_count", drop_count, 16'd0);
        chk("rst_stall", rvvi_stall, 1'b1);
        reset = 1'b0;
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            chk("rst_no_frame", axi.RvviAxiWvalid, 1'b0);
            tick();
        end
        base = mon_frames;
        push(mk_rec(31), 1'b1);
        wait_frames(base + 1, 200);
        chk("frame_count_end", frame_count, exp_frames);
        chk("drop_count_end", drop_count, exp_drop);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
